m31_sbox_arbiter: RTL and testbench
===================================

Name: m31_sbox_arbiter

Overview:
- Shares one pipelined x^5 S-box (m31_sbox, 12-cycle latency, no stall) between NUM_REQ round engines.
- Round-robin arbitration with burst locking, so a requester can push a full state vector contiguously.
- Issues at most one operand per cycle.
- A tag pipeline routes each result back to its originating requester with a last marker.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SBOX_LAT, M31_SBOX_LAT (=12), S-box latency in cycles; must equal the instantiated S-box latency.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_data_i  in  NUM_REQ x 31  per-requester operand (m31_t, canonical, < p)
- req_last_i  in  NUM_REQ  beat is last of burst; releases the lock
- req_ready_o  out  NUM_REQ  per-requester accept, at most one bit high
- resp_valid_o  out  NUM_REQ  one-hot result strobe, no backpressure
- resp_data_o  out  31  result x^5 mod p, shared by all requesters
- resp_last_o  out  1  result belongs to a last beat
- busy_o  out  1  lock held or any operation in flight

Behaviour:
- FSM states: IDLE, LOCKED. Registers:
  - state
  - grant_id (log2 NUM_REQ bits)
  - rr_ptr
  - tag pipeline of SBOX_LAT entries, each {valid, id, last}
- IDLE:
  - sel = first i with req_valid_i[i], scanning from rr_ptr upward with wrap.
  - req_ready_o[sel]=1, combinational, same cycle.
  - If no valid request, all ready=0.
- Beat accepted = req_valid_i[g] & req_ready_o[g]. On accept:
  - drive operand to the S-box and push tag {1, g, req_last_i[g]}.
  - Otherwise drive operand 0 and push tag valid=0.
- IDLE accept with last=0: go to LOCKED, grant_id=sel.
- IDLE accept with last=1: stay IDLE, rr_ptr=sel+1 (mod NUM_REQ).
- LOCKED:
  - req_ready_o[grant_id]=1 every cycle; all others 0.
  - Valid low from the owner = bubble, lock kept.
  - Accept with last=1 returns to IDLE, rr_ptr=grant_id+1.
- No fairness timeout: a burst owns the S-box until its last beat.
- Response:
  - When the tag at stage SBOX_LAT-1 is valid, resp_valid_o[id]=1 and resp_last_o=tag.last in that cycle.
  - resp_data_o equals the S-box output aligned to that tag.
  - Tag pipeline delay matches the S-box exactly: a beat accepted in cycle t responds in cycle t+SBOX_LAT.
  - With no valid tag: resp_valid_o=0, resp_last_o=0; resp_data_o is don't-care but must be driven.
- Throughput: 1 beat/cycle sustained. Back-to-back bursts from different requesters have zero idle cycles, because IDLE grant is combinational.
- busy_o = (state==LOCKED) | OR of tag valids.
- Reset (asynchronous assert), including mid-operation:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All tags cleared; in-flight results are discarded and never strobed.
  - Outputs: req_ready_o=0 while rst_n low; resp_valid_o=0, resp_last_o=0, busy_o=0.
  - S-box internal registers reset synchronously from the same rst_n; garbage there is masked by the cleared tags.
- Requester contract: an operand must be held stable while valid is high and ready is low.

Decomposition:
- m31_pkg holds:
  - m31_t, M31_P
  - new constant M31_SBOX_LAT=12
  - typedef sbox_tag_t {logic valid; logic [2:0] id; logic last;}
- Sub-module: m31_sbox, instantiated once, inputs in_i/out_o.
- Round-robin select is a local function, not a module.

Test Plan:
- Single requester 0, data 2, last=1 -> ready same cycle; 12 cycles later resp_valid_o=4'b0001, data 32, last=1.
- Boundary operands 0, 1, 3, 2147483646 back-to-back from requester 1 -> results 0, 1, 243, 2147483646 on consecutive cycles, all with valid 4'b0010.
- Requesters 0 and 2 both valid with single-beat last=1, rr_ptr=0 -> grants 0, 2, 0, 2...; requester 1 valid added later gets the slot after 0 before 2.
- Requester 1 bursts 16 beats (last on 16th) with a 3-cycle valid gap mid-burst, requester 3 valid throughout -> requester 3 ready stays 0 until the cycle after beat 16; results are 16 strobes to requester 1, last only on the 16th.
- Reset asserted 5 cycles after 4 beats are issued, released 2 cycles later -> no resp_valid_o for those beats, busy_o=0, and the next request completes with correct data after 12 cycles.
- Random traffic on all requesters, 10k beats -> scoreboard confirms every result equals x^5 mod p, routed to the correct id, in per-requester issue order.

Source files
------------

// File: rtl/m31_pkg.sv
`default_nettype none
//============================================================================
// Module  : m31_pkg
// Purpose : Shared types and helpers for Mersenne-31 (p = 2^31 - 1) datapaths.
//           Holds the canonical field element type, the modulus, the fixed
//           S-box pipeline depth and the result-routing tag carried alongside
//           each S-box operand.
// Revision: 1.0 - initial release
//============================================================================
package m31_pkg;

   typedef logic [30:0] m31_t;

   localparam m31_t M31_P        = 31'h7FFF_FFFF;
   localparam int   M31_SBOX_LAT = 12;

   // Travels beside each operand so the result can be steered back to its
   // originating requester. id is wide enough for up to 8 requesters.
   typedef struct packed {
      logic       valid;
      logic [2:0] id;
      logic       last;
   } sbox_tag_t;

   // Reduce a product of two canonical elements into canonical form.
   // Because 2^31 == 1 mod p, the high and low 31-bit halves simply add.
   // The sum is at most 2^32 - 2, so one fold lands in [0, p] and a final
   // compare maps p onto 0.
   function automatic m31_t m31_reduce(input logic [61:0] prod);
      logic [31:0] sum;
      m31_t        fold;
      sum  = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
      fold = sum[30:0] + 31'(sum[31]);
      return (fold == M31_P) ? '0 : fold;
   endfunction

endpackage
`default_nettype wire

// File: rtl/m31_sbox.sv
`default_nettype none
//============================================================================
// Module  : m31_sbox
// Purpose : Fully pipelined x^5 mod p S-box over M31, one operand per cycle,
//           no stall. Latency is M31_SBOX_LAT cycles: an operand sampled at
//           the end of cycle t appears on out_o during cycle t+M31_SBOX_LAT.
// Ports   : clk    - system clock
//           rst_n  - active-low reset, applied synchronously to all stages
//           in_i   - canonical operand
//           out_o  - in_i^5 mod p, delayed by M31_SBOX_LAT cycles
// Revision: 1.0 - initial release
//============================================================================
module m31_sbox
   import m31_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  m31_t in_i,
   output m31_t out_o
);

   // Seven stages do the arithmetic (square, square, multiply, each split
   // into a multiply stage and a reduce stage); the rest pad out the latency.
   localparam int PAD = M31_SBOX_LAT - 7;

   m31_t        r_x1, r_x2, r_x3, r_x4, r_x5;
   logic [61:0] r_p2, r_p4, r_p6;
   m31_t        r_sq3, r_q5, r_r7;
   m31_t        r_pad [PAD];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x1  <= '0;
         r_x2  <= '0;
         r_x3  <= '0;
         r_x4  <= '0;
         r_x5  <= '0;
         r_p2  <= '0;
         r_sq3 <= '0;
         r_p4  <= '0;
         r_q5  <= '0;
         r_p6  <= '0;
         r_r7  <= '0;
         for (int k = 0; k < PAD; k++) begin
            r_pad[k] <= '0;
         end
      end else begin
         r_x1  <= in_i;
         r_p2  <= 62'(r_x1) * 62'(r_x1);
         r_x2  <= r_x1;
         r_sq3 <= m31_reduce(r_p2);
         r_x3  <= r_x2;
         r_p4  <= 62'(r_sq3) * 62'(r_sq3);
         r_x4  <= r_x3;
         r_q5  <= m31_reduce(r_p4);
         r_x5  <= r_x4;
         r_p6  <= 62'(r_q5) * 62'(r_x5);
         r_r7  <= m31_reduce(r_p6);
         r_pad[0] <= r_r7;
         for (int k = 1; k < PAD; k++) begin
            r_pad[k] <= r_pad[k-1];
         end
      end
   end

   assign out_o = r_pad[PAD-1];

endmodule
`default_nettype wire

// File: rtl/m31_sbox_arbiter.sv
`default_nettype none
//============================================================================
// Module  : m31_sbox_arbiter
// Purpose : Shares one pipelined x^5 S-box between NUM_REQ round engines.
//           Round-robin grant with burst locking, at most one operand issued
//           per cycle, and a tag pipeline that routes each result back to its
//           requester together with the burst-last marker.
// Ports   : clk           - system clock
//           rst_n         - asynchronous active-low reset
//           req_valid_i   - per-requester operand valid
//           req_data_i    - per-requester canonical operand
//           req_last_i    - beat is last of its burst (releases the lock)
//           req_ready_o   - per-requester accept, at most one bit high
//           resp_valid_o  - one-hot result strobe, no backpressure
//           resp_data_o   - x^5 mod p, shared by all requesters
//           resp_last_o   - result belongs to a last beat
//           busy_o        - lock held or any operation in flight
// Revision: 1.0 - initial release
//============================================================================
module m31_sbox_arbiter
   import m31_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int SBOX_LAT = M31_SBOX_LAT   // must match the S-box depth
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  m31_t [NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0] req_last_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   output logic [NUM_REQ-1:0] resp_valid_o,
   output m31_t               resp_data_o,
   output logic               resp_last_o,
   output logic               busy_o
);

   localparam int IDW = $clog2(NUM_REQ);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // First valid requester at or after ptr, wrapping; MSB flags a hit.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IDW-1:0]     ptr);
      logic           found;
      logic [IDW-1:0] pick;
      logic [IDW-1:0] idx;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NUM_REQ);
         if (!found && valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      return {found, pick};
   endfunction

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
      return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
   endfunction

   logic [0:0]         r_state;
   logic [IDW-1:0]     r_grant_id;
   logic [IDW-1:0]     r_rr_ptr;
   sbox_tag_t          r_tag [SBOX_LAT];

   logic               w_found;
   logic [IDW-1:0]     w_sel;
   logic [IDW-1:0]     w_gid;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_accept;
   logic               w_last;
   m31_t               w_operand;
   sbox_tag_t          w_push;
   sbox_tag_t          w_out_tag;
   m31_t               w_sbox_out;
   logic               w_inflight;

   //------------------------------------------------------------------------
   // Grant: combinational in IDLE so a new burst can start in the very cycle
   // the previous one released the lock.
   //------------------------------------------------------------------------
   always_comb begin
      {w_found, w_sel} = rr_pick(req_valid_i, r_rr_ptr);
      w_gid   = (r_state == ST_LOCKED) ? r_grant_id : w_sel;
      w_ready = '0;
      if (rst_n) begin
         if (r_state == ST_LOCKED) begin
            w_ready[r_grant_id] = 1'b1;
         end else if (w_found) begin
            w_ready[w_sel] = 1'b1;
         end
      end
      w_accept  = |(req_valid_i & w_ready);
      w_last    = req_last_i[w_gid];
      w_operand = w_accept ? req_data_i[w_gid] : '0;
      w_push    = '{valid: w_accept, id: 3'(w_gid), last: w_accept & w_last};
   end

   assign req_ready_o = w_ready;

   //------------------------------------------------------------------------
   // Lock FSM and round-robin pointer
   //------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (w_last) begin
                  r_rr_ptr <= next_id(w_sel);
               end else begin
                  r_state    <= ST_LOCKED;
                  r_grant_id <= w_sel;
               end
            end
            ST_LOCKED: begin
               if (w_last) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= next_id(r_grant_id);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   //------------------------------------------------------------------------
   // Tag pipeline: same depth as the S-box, so the tag leaving the last
   // stage describes exactly the result on the S-box output. Clearing it on
   // reset is what discards in-flight results.
   //------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SBOX_LAT; k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         r_tag[0] <= w_push;
         for (int k = 1; k < SBOX_LAT; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   m31_sbox u_sbox (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (w_operand),
      .out_o (w_sbox_out)
   );

   //------------------------------------------------------------------------
   // Response routing
   //------------------------------------------------------------------------
   assign w_out_tag = r_tag[SBOX_LAT-1];

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
         assign resp_valid_o[i] = w_out_tag.valid && (w_out_tag.id == 3'(i));
      end
   endgenerate

   assign resp_last_o = w_out_tag.valid & w_out_tag.last;
   assign resp_data_o = w_sbox_out;

   always_comb begin
      w_inflight = 1'b0;
      for (int k = 0; k < SBOX_LAT; k++) begin
         w_inflight = w_inflight | r_tag[k].valid;
      end
   end

   assign busy_o = (r_state == ST_LOCKED) | w_inflight;

endmodule
`default_nettype wire

// File: tb/tb_m31_sbox_arbiter.sv
`default_nettype none
//============================================================================
// Module  : tb_m31_sbox_arbiter
// Purpose : Self-checking bench for m31_sbox_arbiter: directed vector tables
//           for grant behaviour and boundary operands, hand sequences for
//           burst locking and mid-operation reset, then random traffic with
//           an in-order result scoreboard.
// Revision: 1.0 - initial release
//============================================================================
module tb_m31_sbox_arbiter;
   import m31_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req_valid = '0;
   m31_t [N-1:0] req_data = '0;
   logic [N-1:0] req_last = '0;
   logic [N-1:0] req_ready;
   logic [N-1:0] resp_valid;
   m31_t         resp_data;
   logic         resp_last;
   logic         busy;

   always #5 clk = ~clk;

   m31_sbox_arbiter #(.NUM_REQ(N), .SBOX_LAT(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_last_i   (req_last),
      .req_ready_o  (req_ready),
      .resp_valid_o (resp_valid),
      .resp_data_o  (resp_data),
      .resp_last_o  (resp_last),
      .busy_o       (busy)
   );

   typedef struct {
      int   id;
      m31_t data;
      logic last;
      int   cyc;
   } sb_t;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] last;
      logic [N-1:0] exp_ready;
   } arb_vec_t;

   typedef struct {
      m31_t data;
      m31_t exp;
   } bnd_vec_t;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   m31_t         exp_next [N];
   logic [N-1:0] last_acc;
   sb_t          sb [$];

   function automatic m31_t pow5(input m31_t x);
      longint unsigned p, a, s;
      p = 64'(M31_P);
      a = 64'(x);
      s = (a * a) % p;
      s = (s * s) % p;
      s = (s * a) % p;
      return m31_t'(s);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle observation, called once before every clock edge.
   task automatic monitor();
      sb_t e;
      last_acc = req_valid & req_ready;
      if (!rst_n) begin
         sb.delete();
         check("rst_ready", 64'(req_ready), 0);
         check("rst_resp_valid", 64'(resp_valid), 0);
         check("rst_resp_last", 64'(resp_last), 0);
         check("rst_busy", 64'(busy), 0);
         last_acc = '0;
         return;
      end
      check("ready_onehot", 64'($countones(req_ready) <= 1), 1);
      if (resp_valid != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 64'(resp_valid), 0);
         end else begin
            e = sb.pop_front();
            check("resp_id", 64'(resp_valid), 64'(1 << e.id));
            check("resp_data", 64'(resp_data), 64'(e.data));
            check("resp_last", 64'(resp_last), 64'(e.last));
            check("resp_latency", 64'(cyc - e.cyc), 64'(LAT));
         end
      end else begin
         check("idle_resp_last", 64'(resp_last), 0);
         if (sb.size() > 0 && sb[0].cyc + LAT == cyc) begin
            e = sb.pop_front();
            check("missing_resp", 64'(resp_valid), 64'(1 << e.id));
         end
      end
      for (int i = 0; i < N; i++) begin
         if (last_acc[i]) sb.push_back('{i, exp_next[i], req_last[i], cyc});
      end
   endtask

   task automatic tick();
      #2;
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input int i, input m31_t d, input logic l, input m31_t e);
      req_valid[i] = 1'b1;
      req_data[i]  = d;
      req_last[i]  = l;
      exp_next[i]  = e;
   endtask

   task automatic drain();
      for (int k = 0; k < LAT + 4; k++) tick();
      check("drain_empty", 64'(sb.size()), 0);
      check("drain_busy", 64'(busy), 0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   arb_vec_t arb_tbl [13];
   bnd_vec_t bnd_tbl [4];
   int       rem [N];
   int       beats;
   int       guard;
   logic     done;

   task automatic present(input int i);
      m31_t d;
      d = ($urandom_range(0, 15) == 0) ? (M31_P - 31'd1) : m31_t'($urandom % 32'h7FFF_FFFF);
      drive(i, d, (rem[i] == 1), pow5(d));
   endtask

   initial begin
      arb_tbl[0]  = '{4'b0101, 4'b1111, 4'b0001};
      arb_tbl[1]  = '{4'b0101, 4'b1111, 4'b0100};
      arb_tbl[2]  = '{4'b0101, 4'b1111, 4'b0001};
      arb_tbl[3]  = '{4'b0111, 4'b1111, 4'b0010};
      arb_tbl[4]  = '{4'b0101, 4'b1111, 4'b0100};
      arb_tbl[5]  = '{4'b1000, 4'b1111, 4'b1000};
      arb_tbl[6]  = '{4'b0000, 4'b1111, 4'b0000};
      arb_tbl[7]  = '{4'b1010, 4'b1111, 4'b0010};
      arb_tbl[8]  = '{4'b1010, 4'b1111, 4'b1000};
      arb_tbl[9]  = '{4'b0001, 4'b0000, 4'b0001};
      arb_tbl[10] = '{4'b0110, 4'b1111, 4'b0001};
      arb_tbl[11] = '{4'b0111, 4'b1111, 4'b0001};
      arb_tbl[12] = '{4'b0110, 4'b1111, 4'b0010};

      bnd_tbl[0] = '{31'd0, 31'd0};
      bnd_tbl[1] = '{31'd1, 31'd1};
      bnd_tbl[2] = '{31'd3, 31'd243};
      bnd_tbl[3] = '{31'd2147483646, 31'd2147483646};

      for (int i = 0; i < N; i++) exp_next[i] = '0;

      // Reset state, with a request pending to prove ready is held low.
      @(posedge clk);
      #1;
      req_valid = 4'b0001;
      reset_pulse();
      req_valid = '0;
      #1;
      check("post_rst_busy", 64'(busy), 0);
      check("post_rst_ready", 64'(req_ready), 0);
      check("post_rst_resp", 64'(resp_valid), 0);

      // Single beat from requester 0: 2^5 = 32 twelve cycles later.
      drive(0, 31'd2, 1'b1, 31'd32);
      #1;
      check("single_ready", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;
      tick();
      check("single_busy", 64'(busy), 1);
      drain();

      // Boundary operands back to back from requester 1.
      for (int v = 0; v < 4; v++) begin
         drive(1, bnd_tbl[v].data, 1'b1, bnd_tbl[v].exp);
         #1;
         check($sformatf("bnd_ready[%0d]", v), 64'(req_ready), 64'(4'b0010));
         tick();
      end
      req_valid = '0;
      drain();

      // Arbitration table from a fresh pointer.
      reset_pulse();
      for (int v = 0; v < 13; v++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = arb_tbl[v].valid[i];
            req_last[i]  = arb_tbl[v].last[i];
            req_data[i]  = m31_t'(100 + v * 4 + i);
            exp_next[i]  = pow5(req_data[i]);
         end
         #1;
         check($sformatf("arb_ready[%0d]", v), 64'(req_ready), 64'(arb_tbl[v].exp_ready));
         tick();
      end
      req_valid = '0;
      drain();

      // 16-beat burst from requester 1 with a 3-cycle bubble; requester 3
      // waits the whole time and is granted only after the last beat.
      for (int b = 1; b <= 16; b++) begin
         if (b == 9) begin
            for (int g = 0; g < 3; g++) begin
               req_valid[1] = 1'b0;
               #1;
               check("burst_gap_ready", 64'(req_ready), 64'(4'b0010));
               check("burst_gap_busy", 64'(busy), 1);
               tick();
            end
         end
         drive(1, m31_t'(1000 + b), (b == 16), pow5(m31_t'(1000 + b)));
         if (b >= 2) drive(3, 31'd5555, 1'b1, pow5(31'd5555));
         #1;
         check("burst_ready", 64'(req_ready), 64'(4'b0010));
         tick();
      end
      req_valid[1] = 1'b0;
      #1;
      check("post_burst_ready", 64'(req_ready), 64'(4'b1000));
      tick();
      req_valid = '0;
      drain();

      // Reset in the middle of four in-flight beats.
      for (int k = 0; k < 4; k++) begin
         drive(2, m31_t'(10 + k), 1'b1, pow5(m31_t'(10 + k)));
         tick();
      end
      req_valid = '0;
      for (int k = 0; k < 5; k++) tick();
      rst_n = 1'b0;
      drive(3, 31'd9, 1'b1, pow5(31'd9));
      #1;
      check("midrst_busy", 64'(busy), 0);
      check("midrst_ready", 64'(req_ready), 0);
      tick();
      tick();
      req_valid = '0;
      rst_n = 1'b1;
      #1;
      check("midrst_release_busy", 64'(busy), 0);
      for (int k = 0; k < LAT + 2; k++) tick();
      drive(0, 31'd7, 1'b1, 31'd16807);
      tick();
      req_valid = '0;
      drain();

      // Random traffic, 10k beats, scoreboard in issue order.
      for (int i = 0; i < N; i++) rem[i] = 0;
      beats = 0;
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 60000) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               if (rem[i] > 0) begin
                  if ($urandom_range(0, 2) == 0) present(i);
               end else if (beats < 10000 && $urandom_range(0, 3) == 0) begin
                  rem[i] = $urandom_range(1, 6);
                  present(i);
               end
            end
         end
         tick();
         guard++;
         for (int i = 0; i < N; i++) begin
            if (last_acc[i]) begin
               beats++;
               rem[i]--;
               req_valid[i] = 1'b0;
               if (rem[i] > 0 && $urandom_range(0, 3) != 0) present(i);
            end
         end
         done = (beats >= 10000) && (req_valid == '0) &&
                (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0);
      end
      check("random_done", 64'(done), 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
